// File: rtl/vga_obj_pkg.sv
// Shared constants, select encodings and FSM state type for the VGA object locator.
package vga_obj_pkg;

    localparam int unsigned COORD_W   = 10;
    localparam int unsigned FOUND_BIT = 15;
    localparam int unsigned FCNT_LSB  = 10;
    localparam int unsigned FCNT_W    = 5;
    localparam int unsigned CNT_W     = 19;

    localparam logic [1:0] SEL_MIN_X = 2'd0;
    localparam logic [1:0] SEL_MAX_X = 2'd1;
    localparam logic [1:0] SEL_MIN_Y = 2'd2;
    localparam logic [1:0] SEL_MAX_Y = 2'd3;

    typedef enum logic {StIdle, StAccum} state_e;

endpackage

// File: rtl/obj_minmax_acc.sv
// One-axis min/max accumulator. The *_now outputs include the current cycle's update so an
// end-of-frame latch can capture a pixel arriving on the same cycle as eof.
module obj_minmax_acc #(
    parameter int unsigned W = 10
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clear_i,
    input  logic         update_i,
    input  logic [W-1:0] coord_i,
    output logic [W-1:0] min_now_o,
    output logic [W-1:0] max_now_o
);

    logic [W-1:0] min_q, min_d;
    logic [W-1:0] max_q, max_d;

    always_comb begin
        min_now_o = (update_i && (coord_i < min_q)) ? coord_i : min_q;
        max_now_o = (update_i && (coord_i > max_q)) ? coord_i : max_q;
        min_d     = clear_i ? '1 : min_now_o;
        max_d     = clear_i ? '0 : max_now_o;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            min_q <= '1;
            max_q <= '0;
        end else begin
            min_q <= min_d;
            max_q <= max_d;
        end
    end

endmodule

// File: rtl/vga_object_locator.sv
// Per-frame bounding-box tracker feeding a 16-bit PIO: {found, frame_cnt[4:0], coord[9:0]}.
// Define OBJ_PIXCOUNT_EN to require MIN_PIXELS matched pixels before reporting 'found'.
module vga_object_locator
    import vga_obj_pkg::*;
#(
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned COORD_W    = vga_obj_pkg::COORD_W,
    parameter int unsigned MIN_PIXELS = 64
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               sof_i,
    input  logic               eof_i,
    input  logic               pix_valid_i,
    input  logic [COORD_W-1:0] pix_x_i,
    input  logic [COORD_W-1:0] pix_y_i,
    input  logic               pix_match_i,
    input  logic [1:0]         sel_i,
    output logic [15:0]        data_out_o,
    output logic               frame_done_o
);

    localparam logic [COORD_W-1:0] XLim = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] YLim = COORD_W'(V_ACTIVE);

    state_e              state_q;
    logic                acc_hit_q;
    logic [FCNT_W-1:0]   frame_cnt_q;
    logic                found_q;
    logic [COORD_W-1:0]  min_x_q, max_x_q, min_y_q, max_y_q;
    logic                frame_done_q;
    logic [15:0]         data_out_q;

    logic                acc_upd, latch, hit_now, found_now;
    logic [COORD_W-1:0]  min_x_now, max_x_now, min_y_now, max_y_now;
    logic [COORD_W-1:0]  coord_sel;

    assign acc_upd = (state_q == StAccum) && pix_valid_i && pix_match_i &&
                     (pix_x_i < XLim) && (pix_y_i < YLim);
    assign latch   = eof_i && (state_q == StAccum);
    assign hit_now = acc_hit_q | acc_upd;

    obj_minmax_acc #(.W(COORD_W)) u_acc_x (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clear_i  (sof_i),
        .update_i (acc_upd),
        .coord_i  (pix_x_i),
        .min_now_o(min_x_now),
        .max_now_o(max_x_now)
    );

    obj_minmax_acc #(.W(COORD_W)) u_acc_y (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clear_i  (sof_i),
        .update_i (acc_upd),
        .coord_i  (pix_y_i),
        .min_now_o(min_y_now),
        .max_now_o(max_y_now)
    );

`ifdef OBJ_PIXCOUNT_EN
    localparam logic [CNT_W-1:0] MinPix = CNT_W'(MIN_PIXELS);

    logic [CNT_W-1:0] acc_cnt_q, cnt_now;

    assign cnt_now   = (acc_upd && (acc_cnt_q != '1)) ? acc_cnt_q + 1'b1 : acc_cnt_q;
    assign found_now = (cnt_now >= MinPix);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_cnt_q <= '0;
        end else begin
            acc_cnt_q <= sof_i ? '0 : cnt_now;
        end
    end
`else
    assign found_now = hit_now;
`endif

    always_comb begin
        coord_sel = '0;
        unique case (sel_i)
            SEL_MIN_X: coord_sel = min_x_q;
            SEL_MAX_X: coord_sel = max_x_q;
            SEL_MIN_Y: coord_sel = min_y_q;
            SEL_MAX_Y: coord_sel = max_y_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            acc_hit_q    <= 1'b0;
            frame_cnt_q  <= '0;
            found_q      <= 1'b0;
            min_x_q      <= '0;
            max_x_q      <= '0;
            min_y_q      <= '0;
            max_y_q      <= '0;
            frame_done_q <= 1'b0;
            data_out_q   <= '0;
        end else begin
            if (sof_i) begin
                state_q <= StAccum;
            end
            acc_hit_q    <= sof_i ? 1'b0 : hit_now;
            frame_done_q <= latch;
            // Latch uses this cycle's pixel; a coincident sof only clears the accumulators.
            if (latch) begin
                frame_cnt_q <= frame_cnt_q + 1'b1;
                found_q     <= found_now;
                min_x_q     <= found_now ? min_x_now : '0;
                max_x_q     <= found_now ? max_x_now : '0;
                min_y_q     <= found_now ? min_y_now : '0;
                max_y_q     <= found_now ? max_y_now : '0;
            end
            data_out_q <= {found_q, frame_cnt_q, 10'(coord_sel)};
        end
    end

    assign data_out_o   = data_out_q;
    assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_vga_object_locator.sv
// Directed bench with a behavioural bounding-box model feeding an expected-result queue.
module tb_vga_object_locator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sof, eof, pv, pm;
    logic [9:0]  px, py;
    logic [1:0]  sel;
    logic [15:0] data_out;
    logic        frame_done;

    int checks   = 0;
    int failures = 0;

    int  m_minx, m_maxx, m_miny, m_maxy, m_cnt, m_fcnt;
    bit  m_hit, m_active;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    vga_object_locator dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .sof_i       (sof),
        .eof_i       (eof),
        .pix_valid_i (pv),
        .pix_x_i     (px),
        .pix_y_i     (py),
        .pix_match_i (pm),
        .sel_i       (sel),
        .data_out_o  (data_out),
        .frame_done_o(frame_done)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_minx = 1023; m_maxx = 0; m_miny = 1023; m_maxy = 0;
        m_hit  = 1'b0; m_cnt = 0;
    endtask

    task automatic model_pixel(input int x, input int y, input bit m);
        if (m_active && m && x < 640 && y < 480) begin
            if (x < m_minx) m_minx = x;
            if (x > m_maxx) m_maxx = x;
            if (y < m_miny) m_miny = y;
            if (y > m_maxy) m_maxy = y;
            m_hit = 1'b1;
            m_cnt++;
        end
    endtask

    // Frame count advances first: the latched word carries the post-increment count.
    task automatic model_latch(input int nf);
        bit found;
        logic [15:0] hdr;
        int vals[4];
`ifdef OBJ_PIXCOUNT_EN
        found = (m_cnt >= 64);
`else
        found = m_hit;
`endif
        m_fcnt = (m_fcnt + 1) % 32;
        hdr = {found, 5'(m_fcnt), 10'd0};
        vals = '{m_minx, m_maxx, m_miny, m_maxy};
        for (int s = 0; s < nf; s++) begin
            exp_q.push_back(found ? (hdr | 16'(vals[s])) : hdr);
        end
    endtask

    task automatic pixel(input int x, input int y, input bit m);
        pv = 1'b1; px = 10'(x); py = 10'(y); pm = m;
        model_pixel(x, y, m);
        cyc();
        pv = 1'b0; pm = 1'b0;
    endtask

    task automatic start_frame();
        sof = 1'b1;
        model_clear();
        m_active = 1'b1;
        cyc();
        sof = 1'b0;
    endtask

    task automatic wait_done_and_read(input int nf);
        int n = 0;
        while (!frame_done && n < 4) begin
            cyc();
            n++;
        end
        chk("frame_done", {15'd0, frame_done}, 16'd1);
        cyc();
        chk("frame_done_pulse", {15'd0, frame_done}, 16'd0);
        for (int s = 0; s < nf; s++) begin
            sel = 2'(s);
            cyc();
            cyc();
            if (exp_q.size() == 0) begin
                chk("scoreboard_empty", 16'd1, 16'd0);
            end else begin
                chk($sformatf("field_sel%0d", s), data_out, exp_q.pop_front());
            end
        end
    endtask

    task automatic end_frame(input int nf);
        eof = 1'b1;
        model_latch(nf);
        cyc();
        eof = 1'b0;
        wait_done_and_read(nf);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        m_active = 1'b0;
        m_fcnt = 0;
        model_clear();
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic expect_idle_eof(input string tag);
        eof = 1'b1;
        cyc();
        eof = 1'b0;
        chk({tag, "_no_done0"}, {15'd0, frame_done}, 16'd0);
        cyc();
        chk({tag, "_no_done1"}, {15'd0, frame_done}, 16'd0);
        sel = 2'd0;
        cyc();
        chk({tag, "_data"}, data_out, 16'h0000);
    endtask

    initial begin
        sof = 0; eof = 0; pv = 0; pm = 0; px = '0; py = '0; sel = 2'd0; rst_n = 1'b1;
        #2;
        do_reset();
        chk("reset_data_out", data_out, 16'h0000);
        chk("reset_frame_done", {15'd0, frame_done}, 16'd0);

        // Pixels and eof before any sof are ignored.
        pixel(100, 50, 1'b1);
        expect_idle_eof("idle");

        start_frame();
        pixel(100, 50, 1'b1);
        pixel(300, 200, 1'b1);
        pixel(500, 10, 1'b0);
        pixel(20, 400, 1'b1);
        end_frame(4);

        start_frame();
        pixel(30, 30, 1'b0);
        end_frame(4);

        start_frame();
        pixel(700, 10, 1'b1);
        pixel(5, 500, 1'b1);
        end_frame(4);

        // Drive the 5-bit frame counter through its wrap back to zero.
        for (int f = 0; f < 29; f++) begin
            start_frame();
            end_frame(0);
        end
        sel = 2'd0;
        cyc();
        cyc();
        chk("wrap_cnt_zero", data_out, 16'h0000);

        // sof and eof together: latch pre-clear state plus this pixel, then clear.
        start_frame();
        sof = 1'b1; eof = 1'b1; pv = 1'b1; px = 10'd7; py = 10'd9; pm = 1'b1;
        model_pixel(7, 9, 1'b1);
        model_latch(3);
        model_clear();
        cyc();
        sof = 1'b0; eof = 1'b0; pv = 1'b0; pm = 1'b0;
        wait_done_and_read(3);

        start_frame();
        pixel(639, 479, 1'b1);
        end_frame(4);

`ifdef OBJ_PIXCOUNT_EN
        start_frame();
        for (int i = 0; i < 63; i++) pixel(10 + i, 20 + i, 1'b1);
        end_frame(4);
        start_frame();
        for (int i = 0; i < 64; i++) pixel(10 + i, 20 + 2 * i, 1'b1);
        end_frame(4);
`endif

        // Reset mid-frame: a following eof without sof must not produce a result.
        start_frame();
        pixel(50, 60, 1'b1);
        do_reset();
        expect_idle_eof("midreset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1);
    end

endmodule
